fft_power_avg: RTL and testbench
================================

# fft_power_avg

Downstream consumer of `serial_fft`. It accepts the complex FFT output stream bin by bin and computes per-bin power (re² + im²). It averages that power over 2^AVG_LOG2 consecutive frames, then streams the averaged spectrum out under valid/ready with a frame-end marker. It also reports the peak bin of the averaged spectrum for the downstream display/detection logic.

## Interface
- `N_POINTS`, 64: bins per frame; power of two, ≥ 4.
- `DATA_W`, 16: signed width of `r_value`/`i_value` in `fft_pkg::complex_t`.
- `AVG_LOG2`, 2: log2 of frames averaged; 0 means no averaging.
- `clk`  in  1  clock.
- `arstn`  in  1  reset, synchronous, active-low.
- `start_i`  in  1  begin an averaging run; honoured only in IDLE.
- `data_i`  in  `fft_pkg::complex_t`  FFT bin, bin 0 first, natural order.
- `valid_i`  in  1  `data_i` valid.
- `ready_o`  out  1  block can accept input.
- `pwr_o`  out  PWR_W  averaged power of `bin_o`.
- `bin_o`  out  log2(N_POINTS)  bin index of `pwr_o`.
- `last_o`  out  1  high with bin N_POINTS-1.
- `valid_o`  out  1  output beat valid.
- `ready_i`  in  1  downstream accepts beat.
- `peak_bin_o`  out  log2(N_POINTS)  bin with maximum averaged power.
- `peak_pwr_o`  out  PWR_W  that maximum.
- `peak_valid_o`  out  1  one-cycle pulse, peak outputs updated.
- `busy_o`  out  1  state ≠ IDLE.

## Operation
- PWR_W = 2·DATA_W+1; ACC_W = PWR_W+AVG_LOG2. All arithmetic is exact, with no saturation or rounding. Output is acc >> AVG_LOG2, which is a truncating divide.
- Accumulator is an N_POINTS × ACC_W register array.
- States:
  - IDLE: `start_i` → ACCUM, with bin_cnt = 0 and frame_cnt = 0.
  - ACCUM: `ready_o` = 1. Each handshake (valid_i & ready_o) registers the power and the bin.
    - Next cycle: acc[bin] ← power if frame_cnt = 0, else acc[bin] + power. The first frame overwrites, so no clear pass is needed.
    - bin_cnt wraps at N_POINTS-1 and increments frame_cnt.
    - The handshake of the last bin of the last frame → DRAIN.
  - DRAIN (1 cycle): final accumulator write completes. Output registers load bin 0 with valid_o = 1. → DUMP.
  - DUMP: each output handshake loads the next bin. The handshake with last_o → IDLE.
- Peak tracking during DUMP: on each output handshake, update if pwr > current peak (strict). Ties keep the lowest bin. Peak is reset to bin 0 / 0 at DRAIN.
- Peak is published on the final handshake. `peak_valid_o` is high for one cycle, and `peak_*_o` hold their value until the next run's publication.
- `ready_o` = 0 outside ACCUM. `valid_i` gaps in ACCUM simply stall counters.
- `start_i` outside IDLE is ignored.

## Timing
- Reset values: all outputs 0; state IDLE; counters 0; accumulator contents don't-care, because the first frame overwrites them.
- Reset mid-run aborts to IDLE immediately. No partial output is produced.
- `ready_o` is a combinational decode of state. All other outputs are registered.
- Last input handshake at edge t gives state DRAIN after t and `valid_o` = 1 after t+1.
- While `valid_o` & !`ready_i`, `pwr_o`/`bin_o`/`last_o` stay stable.
- Throughput is one bin per cycle on both sides. An output run takes N_POINTS cycles at ready_i = 1.
- Minimum start-to-peak time is 2^AVG_LOG2·N_POINTS + N_POINTS + 2 cycles.

## Structure
- Add to `fft_pkg`:
  - `pwr_t`, a logic vector of width PWR_W, derived from the package data width.
  - `power_of(complex_t)`, a function returning r² + i² as `pwr_t`.
- The output/peak stage is natural as a sub-module, `fft_peak_track`. It takes the valid/ready beat and emits the peak pulse.

## Test plan
All cases use N_POINTS = 8, AVG_LOG2 = 2 unless stated.
- Constant input r=100, i=0 for 4 frames → every pwr_o = 10000, last_o on bin 7, peak_bin_o = 0 (tie rule), peak_pwr_o = 10000.
- Only bin 5 = (3, 4), others 0, all frames → bin 5 pwr_o = 25, others 0, peak_bin_o = 5.
- Bin 2 r = 10, 20, 30, 40 across frames 0-3 → pwr_o = 750 for bin 2.
- Input (-32768, -32768) in all bins, AVG_LOG2 = 0 → pwr_o = 2^31 exactly, with no wrap.
- Random ready_i (50%) and random valid_i gaps → output sequence identical to the ready_i = 1 run, and pwr_o is stable during stalls.
- Reset asserted mid-ACCUM, then a new start with constant r=1, i=1 → all pwr_o = 2 with no stale data, and ready_o = 0 in IDLE.

Source files
------------

// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT stream types.
//   complex_t  : one FFT bin, signed real/imag parts of FFT_DATA_W bits.
//   pwr_t      : exact bin power, FFT_PWR_W = 2*FFT_DATA_W+1 bits.
//   power_of() : r^2 + i^2 of a complex_t, exact.
package fft_pkg;

    localparam int FFT_DATA_W = 16;
    localparam int FFT_PWR_W  = 2 * FFT_DATA_W + 1;

    typedef struct packed {
        logic signed [FFT_DATA_W-1:0] r_value;
        logic signed [FFT_DATA_W-1:0] i_value;
    } complex_t;

    typedef logic [FFT_PWR_W-1:0] pwr_t;

    // Each square fits in 2*FFT_DATA_W bits as a non-negative value
    // (max (-2^(W-1))^2 = 2^(2W-2)); the extra MSB keeps the sum exact.
    function automatic pwr_t power_of(complex_t c);
        logic signed [2*FFT_DATA_W-1:0] r_ext;
        logic signed [2*FFT_DATA_W-1:0] i_ext;
        logic signed [2*FFT_DATA_W-1:0] rr;
        logic signed [2*FFT_DATA_W-1:0] ii;
        r_ext = {{FFT_DATA_W{c.r_value[FFT_DATA_W-1]}}, c.r_value};
        i_ext = {{FFT_DATA_W{c.i_value[FFT_DATA_W-1]}}, c.i_value};
        rr    = r_ext * r_ext;
        ii    = i_ext * i_ext;
        return {1'b0, rr} + {1'b0, ii};
    endfunction

endpackage

// File: rtl/fft_power_avg_pkg.sv
// fft_power_avg_pkg: control-state encoding for fft_power_avg.
//   state_t : IDLE -> ACCUM -> DRAIN -> DUMP -> IDLE.
package fft_power_avg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DUMP  = 2'd3
    } state_t;

endpackage

// File: rtl/fft_power_avg_if.sv
// fft_power_avg_if: bus bundle of fft_power_avg.
//   Input stream : start_i, data_i, valid_i, ready_o.
//   Output stream: pwr_o, bin_o, last_o, valid_o, ready_i.
//   Status       : peak_bin_o, peak_pwr_o, peak_valid_o, busy_o.
//   slave  : the power averager's view.  master : the surrounding logic's view.
interface fft_power_avg_if #(
    parameter int N_POINTS = 64
);
    import fft_pkg::*;

    localparam int BIN_W = $clog2(N_POINTS);

    logic             start_i;
    complex_t         data_i;
    logic             valid_i;
    logic             ready_o;
    pwr_t             pwr_o;
    logic [BIN_W-1:0] bin_o;
    logic             last_o;
    logic             valid_o;
    logic             ready_i;
    logic [BIN_W-1:0] peak_bin_o;
    pwr_t             peak_pwr_o;
    logic             peak_valid_o;
    logic             busy_o;

    modport slave (
        input  start_i, data_i, valid_i, ready_i,
        output ready_o, pwr_o, bin_o, last_o, valid_o,
               peak_bin_o, peak_pwr_o, peak_valid_o, busy_o
    );

    modport master (
        output start_i, data_i, valid_i, ready_i,
        input  ready_o, pwr_o, bin_o, last_o, valid_o,
               peak_bin_o, peak_pwr_o, peak_valid_o, busy_o
    );

endinterface

// File: rtl/fft_peak_track.sv
// fft_peak_track: output stage of fft_power_avg.
//   load_i       : loads bin 0 (pwr_i) and clears the running peak.
//   rd_bin_o     : bin whose averaged power must be presented on pwr_i.
//   pwr_o/bin_o/last_o/valid_o/ready_i : output beat, held while stalled.
//   peak_*_o     : maximum of the run (lowest bin on ties), published with a
//                  one-cycle peak_valid_o on the last-beat handshake.
module fft_peak_track #(
    parameter int N_POINTS = 64,
    parameter int PWR_W    = 33,
    parameter int BIN_W    = $clog2(N_POINTS)
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             load_i,
    input  logic [PWR_W-1:0] pwr_i,
    output logic [BIN_W-1:0] rd_bin_o,
    output logic [PWR_W-1:0] pwr_o,
    output logic [BIN_W-1:0] bin_o,
    output logic             last_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [BIN_W-1:0] peak_bin_o,
    output logic [PWR_W-1:0] peak_pwr_o,
    output logic             peak_valid_o
);

    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(N_POINTS - 1);

    logic [BIN_W-1:0] trk_bin;
    logic [PWR_W-1:0] trk_pwr;
    logic             out_hs;
    logic             beat_wins;

    always_comb begin
        out_hs    = valid_o & ready_i;
        beat_wins = (pwr_o > trk_pwr);
        rd_bin_o  = valid_o ? bin_o + 1'b1 : '0;
    end

    always_ff @(posedge clk) begin
        if (!arstn) begin
            pwr_o        <= '0;
            bin_o        <= '0;
            last_o       <= 1'b0;
            valid_o      <= 1'b0;
            trk_bin      <= '0;
            trk_pwr      <= '0;
            peak_bin_o   <= '0;
            peak_pwr_o   <= '0;
            peak_valid_o <= 1'b0;
        end else begin
            peak_valid_o <= 1'b0;
            if (load_i) begin
                valid_o <= 1'b1;
                bin_o   <= '0;
                pwr_o   <= pwr_i;
                last_o  <= 1'b0;
                trk_bin <= '0;
                trk_pwr <= '0;
            end else if (out_hs) begin
                if (beat_wins) begin
                    trk_bin <= bin_o;
                    trk_pwr <= pwr_o;
                end
                if (last_o) begin
                    // Publish including the final beat's own comparison.
                    valid_o      <= 1'b0;
                    last_o       <= 1'b0;
                    peak_valid_o <= 1'b1;
                    peak_bin_o   <= beat_wins ? bin_o : trk_bin;
                    peak_pwr_o   <= beat_wins ? pwr_o : trk_pwr;
                end else begin
                    bin_o  <= rd_bin_o;
                    pwr_o  <= pwr_i;
                    last_o <= (rd_bin_o == LAST_BIN);
                end
            end
        end
    end

endmodule

// File: rtl/fft_power_avg.sv
// fft_power_avg: per-bin power averaged over 2^AVG_LOG2 FFT frames.
//   clk, arstn : clock, synchronous active-low reset.
//   bus        : fft_power_avg_if.slave - input bin stream, averaged output
//                stream with last marker, peak report, busy status.
// Input beats are registered, then written into the accumulator one cycle
// later; the first frame overwrites so no clear pass is needed.
module fft_power_avg
    import fft_pkg::*;
    import fft_power_avg_pkg::*;
#(
    parameter int N_POINTS = 64,
    parameter int DATA_W   = 16,
    parameter int AVG_LOG2 = 2
) (
    input  logic          clk,
    input  logic          arstn,
    fft_power_avg_if.slave bus
);

    localparam int PWR_W = 2 * DATA_W + 1;
    localparam int ACC_W = PWR_W + AVG_LOG2;
    localparam int BIN_W = $clog2(N_POINTS);
    localparam int FC_W  = AVG_LOG2 + 1;
    localparam logic [BIN_W-1:0] LAST_BIN   = BIN_W'(N_POINTS - 1);
    localparam logic [FC_W-1:0]  LAST_FRAME = FC_W'((1 << AVG_LOG2) - 1);

    state_t           state;
    state_t           state_next;
    logic [BIN_W-1:0] bin_cnt;
    logic [FC_W-1:0]  frame_cnt;
    logic             in_hs;
    logic             last_in;
    logic             load;
    logic             dump_done;

    logic             wr_en;
    logic             wr_first;
    logic [BIN_W-1:0] wr_bin;
    logic [PWR_W-1:0] wr_pwr;

    logic [ACC_W-1:0] acc [N_POINTS];
    logic [ACC_W-1:0] acc_rd;
    logic [BIN_W-1:0] rd_bin;
    logic [PWR_W-1:0] avg_pwr;

    always_ff @(posedge clk) begin
        if (!arstn) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (bus.start_i) state_next = ST_ACCUM;
            ST_ACCUM: if (last_in)     state_next = ST_DRAIN;
            ST_DRAIN:                  state_next = ST_DUMP;
            ST_DUMP:  if (dump_done)   state_next = ST_IDLE;
            default:                   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.ready_o = (state == ST_ACCUM);
        in_hs       = bus.valid_i & (state == ST_ACCUM);
        last_in     = in_hs && (bin_cnt == LAST_BIN) && (frame_cnt == LAST_FRAME);
        load        = (state == ST_DRAIN);
        dump_done   = (state == ST_DUMP) & bus.valid_o & bus.ready_i & bus.last_o;
    end

    always_ff @(posedge clk) begin
        if (!arstn) begin
            bin_cnt    <= '0;
            frame_cnt  <= '0;
            wr_en      <= 1'b0;
            wr_first   <= 1'b0;
            wr_bin     <= '0;
            wr_pwr     <= '0;
            bus.busy_o <= 1'b0;
        end else begin
            bus.busy_o <= (state_next != ST_IDLE);
            wr_en      <= in_hs;
            if (in_hs) begin
                wr_bin   <= bin_cnt;
                wr_pwr   <= power_of(bus.data_i);
                wr_first <= (frame_cnt == '0);
            end
            if (state == ST_IDLE && bus.start_i) begin
                bin_cnt   <= '0;
                frame_cnt <= '0;
            end else if (in_hs) begin
                bin_cnt <= bin_cnt + 1'b1;
                if (bin_cnt == LAST_BIN) frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Contents need no reset: the first frame of every run overwrites them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            acc[wr_bin] <= wr_first ? ACC_W'(wr_pwr) : acc[wr_bin] + ACC_W'(wr_pwr);
        end
    end

    always_comb begin
        acc_rd  = acc[rd_bin];
        avg_pwr = PWR_W'(acc_rd >> AVG_LOG2);
    end

    fft_peak_track #(
        .N_POINTS (N_POINTS),
        .PWR_W    (PWR_W)
    ) u_peak (
        .clk          (clk),
        .arstn        (arstn),
        .load_i       (load),
        .pwr_i        (avg_pwr),
        .rd_bin_o     (rd_bin),
        .pwr_o        (bus.pwr_o),
        .bin_o        (bus.bin_o),
        .last_o       (bus.last_o),
        .valid_o      (bus.valid_o),
        .ready_i      (bus.ready_i),
        .peak_bin_o   (bus.peak_bin_o),
        .peak_pwr_o   (bus.peak_pwr_o),
        .peak_valid_o (bus.peak_valid_o)
    );

endmodule

// File: tb/tb_fft_power_avg.sv
// tb_fft_power_avg: directed, table-driven bench for fft_power_avg.
//   dut_a : N_POINTS=8, AVG_LOG2=2 (vector table, reset-abort sequence).
//   dut_b : N_POINTS=8, AVG_LOG2=0 (full-scale input, latency, start ignored).
module tb_fft_power_avg;
    import fft_pkg::*;

    localparam int N = 8;

    typedef struct {
        int     kind;
        bit     rnd;
        longint exp_pwr [N];
        int     exp_peak_bin;
        longint exp_peak_pwr;
    } vec_t;

    logic clk = 1'b0;
    logic arstn;
    always #5 clk = ~clk;

    fft_power_avg_if #(.N_POINTS(N)) ifa ();
    fft_power_avg_if #(.N_POINTS(N)) ifb ();

    fft_power_avg #(.N_POINTS(N), .DATA_W(16), .AVG_LOG2(2)) dut_a (
        .clk(clk), .arstn(arstn), .bus(ifa)
    );
    fft_power_avg #(.N_POINTS(N), .DATA_W(16), .AVG_LOG2(0)) dut_b (
        .clk(clk), .arstn(arstn), .bus(ifb)
    );

    int       n_pass = 0;
    int       n_total = 0;
    complex_t frames [4][N];
    vec_t     vecs [6];
    longint   cap_pwr [N];
    int       cap_bin [N];
    bit       cap_last [N];
    int       cap_n;
    int       peak_b;
    longint   peak_p;
    bit       got_peak;
    int       stall_errs;
    int       stalls;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic fill_frames(input int kind);
        for (int f = 0; f < 4; f++) begin
            for (int b = 0; b < N; b++) begin
                frames[f][b] = '0;
                case (kind)
                    0: frames[f][b].r_value = 16'sd100;
                    4: begin frames[f][b].r_value = 16'sd1;  frames[f][b].i_value = 16'sd1;  end
                    5: begin frames[f][b].r_value = 16'sd50; frames[f][b].i_value = 16'sd50; end
                    default: ;
                endcase
            end
            case (kind)
                1: begin frames[f][5].r_value = 16'sd3; frames[f][5].i_value = 16'sd4; end
                2: frames[f][2].r_value = 16'(10 * (f + 1));
                3: begin
                    frames[f][3].r_value = -16'sd5; frames[f][3].i_value = 16'sd7;
                    frames[f][6].r_value = 16'sd7;  frames[f][6].i_value = -16'sd5;
                end
                default: ;
            endcase
        end
        if (kind == 3) begin
            frames[0][1].r_value = 16'sd1; frames[0][1].i_value = 16'sd1;
            frames[0][0].i_value = -16'sd3;
            frames[1][0].i_value = -16'sd3;
        end
    endtask

    task automatic start_a();
        @(negedge clk); ifa.start_i = 1'b1;
        @(negedge clk); ifa.start_i = 1'b0;
    endtask

    task automatic feed_a(input bit rnd, input int nbeats);
        for (int k = 0; k < nbeats; k++) begin
            if (rnd) repeat ($urandom_range(0, 2)) @(negedge clk);
            ifa.data_i  = frames[k / N][k % N];
            ifa.valid_i = 1'b1;
            @(negedge clk);
            ifa.valid_i = 1'b0;
            ifa.data_i  = complex_t'($urandom);
        end
    endtask

    task automatic collect_a(input bit rnd);
        bit     held;
        longint hp;
        int     hb;
        bit     hl;
        int     cyc;
        held = 0; hp = 0; hb = 0; hl = 0; cyc = 0;
        cap_n = 0; got_peak = 0; stall_errs = 0; stalls = 0;
        while (!got_peak && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (held && (ifa.valid_o !== 1'b1 || ifa.pwr_o != hp || ifa.bin_o != hb || ifa.last_o != hl))
                stall_errs++;
            held = 0;
            if (ifa.peak_valid_o) begin
                got_peak = 1;
                peak_b   = int'(ifa.peak_bin_o);
                peak_p   = longint'(ifa.peak_pwr_o);
            end
            ifa.ready_i = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (ifa.valid_o && !got_peak) begin
                if (ifa.ready_i) begin
                    if (cap_n < N) begin
                        cap_pwr[cap_n]  = longint'(ifa.pwr_o);
                        cap_bin[cap_n]  = int'(ifa.bin_o);
                        cap_last[cap_n] = ifa.last_o;
                    end
                    cap_n++;
                end else begin
                    held = 1; stalls++;
                    hp = longint'(ifa.pwr_o); hb = int'(ifa.bin_o); hl = ifa.last_o;
                end
            end
        end
        ifa.ready_i = 1'b0;
    endtask

    task automatic check_run(input string tag, input longint exp_pwr [N],
                             input int exp_pb, input longint exp_pp);
        check({tag, "_peak_pulse"}, got_peak, 1);
        check({tag, "_beats"}, cap_n, N);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s_pwr%0d", tag, i), cap_pwr[i], exp_pwr[i]);
            check($sformatf("%s_bin%0d", tag, i), cap_bin[i], i);
            check($sformatf("%s_last%0d", tag, i), cap_last[i], (i == N - 1) ? 1 : 0);
        end
        check({tag, "_peak_bin"}, peak_b, exp_pb);
        check({tag, "_peak_pwr"}, peak_p, exp_pp);
        check({tag, "_busy_done"}, ifa.busy_o, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint exp2 [N];
        arstn = 1'b0;
        ifa.start_i = 0; ifa.data_i = '0; ifa.valid_i = 0; ifa.ready_i = 0;
        ifb.start_i = 0; ifb.data_i = '0; ifb.valid_i = 0; ifb.ready_i = 0;

        vecs[0].kind = 0; vecs[0].rnd = 0; vecs[0].exp_peak_bin = 0; vecs[0].exp_peak_pwr = 10000;
        vecs[0].exp_pwr = '{10000, 10000, 10000, 10000, 10000, 10000, 10000, 10000};
        vecs[1].kind = 1; vecs[1].rnd = 0; vecs[1].exp_peak_bin = 5; vecs[1].exp_peak_pwr = 25;
        vecs[1].exp_pwr = '{0, 0, 0, 0, 0, 25, 0, 0};
        vecs[2].kind = 2; vecs[2].rnd = 0; vecs[2].exp_peak_bin = 2; vecs[2].exp_peak_pwr = 750;
        vecs[2].exp_pwr = '{0, 0, 750, 0, 0, 0, 0, 0};
        vecs[3].kind = 3; vecs[3].rnd = 0; vecs[3].exp_peak_bin = 3; vecs[3].exp_peak_pwr = 74;
        vecs[3].exp_pwr = '{4, 0, 0, 74, 0, 0, 74, 0};
        vecs[4].kind = 3; vecs[4].rnd = 1; vecs[4].exp_peak_bin = 3; vecs[4].exp_peak_pwr = 74;
        vecs[4].exp_pwr = '{4, 0, 0, 74, 0, 0, 74, 0};
        vecs[5].kind = 0; vecs[5].rnd = 1; vecs[5].exp_peak_bin = 0; vecs[5].exp_peak_pwr = 10000;
        vecs[5].exp_pwr = '{10000, 10000, 10000, 10000, 10000, 10000, 10000, 10000};

        repeat (3) @(negedge clk);
        check("rst_valid_o", ifa.valid_o, 0);
        check("rst_pwr_o", ifa.pwr_o, 0);
        check("rst_bin_last", {ifa.bin_o, ifa.last_o}, 0);
        check("rst_peak", {ifa.peak_bin_o, ifa.peak_pwr_o, ifa.peak_valid_o}, 0);
        check("rst_busy", ifa.busy_o, 0);
        check("rst_ready", ifa.ready_o, 0);
        arstn = 1'b1;

        for (int v = 0; v < 6; v++) begin
            fill_frames(vecs[v].kind);
            @(negedge clk);
            check($sformatf("v%0d_ready_idle", v), ifa.ready_o, 0);
            start_a();
            check($sformatf("v%0d_ready_accum", v), ifa.ready_o, 1);
            check($sformatf("v%0d_busy", v), ifa.busy_o, 1);
            feed_a(vecs[v].rnd, 4 * N);
            collect_a(vecs[v].rnd);
            check_run($sformatf("v%0d", v), vecs[v].exp_pwr, vecs[v].exp_peak_bin, vecs[v].exp_peak_pwr);
            if (vecs[v].rnd) check($sformatf("v%0d_stall_stable", v), stall_errs, 0);
            @(negedge clk);
            check($sformatf("v%0d_peak_pulse_end", v), ifa.peak_valid_o, 0);
            check($sformatf("v%0d_peak_hold", v), ifa.peak_pwr_o, vecs[v].exp_peak_pwr);
        end

        // Reset in the middle of accumulation, then a clean run of (1,1).
        fill_frames(5);
        start_a();
        feed_a(0, 10);
        arstn = 1'b0;
        @(negedge clk);
        check("abort_busy", ifa.busy_o, 0);
        check("abort_ready", ifa.ready_o, 0);
        check("abort_valid", ifa.valid_o, 0);
        arstn = 1'b1;
        fill_frames(4);
        start_a();
        feed_a(0, 4 * N);
        collect_a(0);
        for (int i = 0; i < N; i++) exp2[i] = 2;
        check_run("abort", exp2, 0, 2);

        // Full-scale negative input with no averaging.
        ifb.ready_i = 1'b1;
        @(negedge clk); ifb.start_i = 1'b1;
        @(negedge clk); ifb.start_i = 1'b0;
        for (int b = 0; b < N; b++) begin
            ifb.data_i.r_value = -16'sd32768;
            ifb.data_i.i_value = -16'sd32768;
            ifb.valid_i = 1'b1;
            @(negedge clk);
        end
        ifb.valid_i = 1'b0;
        check("b_drain_valid", ifb.valid_o, 0);
        check("b_drain_busy", ifb.busy_o, 1);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check($sformatf("b_valid%0d", i), ifb.valid_o, 1);
            check($sformatf("b_pwr%0d", i), ifb.pwr_o, 64'd2147483648);
            check($sformatf("b_bin%0d", i), ifb.bin_o, i);
            check($sformatf("b_last%0d", i), ifb.last_o, (i == N - 1) ? 1 : 0);
            ifb.start_i = (i == 3);
            @(negedge clk);
        end
        ifb.start_i = 1'b0;
        check("b_peak_pulse", ifb.peak_valid_o, 1);
        check("b_peak_bin", ifb.peak_bin_o, 0);
        check("b_peak_pwr", ifb.peak_pwr_o, 64'd2147483648);
        check("b_valid_end", ifb.valid_o, 0);
        repeat (2) @(negedge clk);
        check("b_start_ignored", ifb.busy_o, 0);
        check("b_ready_idle", ifb.ready_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
